// File: rtl/wvb_rdout_pkg.sv
// Shared FSM state type, default configuration and width helper for the waveform-buffer
// readout scheduler.
package wvb_rdout_pkg;

    localparam int unsigned DefNChan    = 4;
    localparam int unsigned DefAdrWidth = 12;
    localparam int unsigned DefHdrLat   = 2;
    localparam int unsigned DefTimeout  = 1023;

    typedef enum logic [2:0] {
        StIdle,
        StHdrRd,
        StHdrWait,
        StData,
        StDone
    } rdout_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wvb_rr_arb.sv
// Round-robin channel arbiter: picks the first requesting channel after last_i, wrapping.
module wvb_rr_arb
    import wvb_rdout_pkg::*;
#(
    parameter int unsigned NReq = DefNChan,
    localparam int unsigned IdxW = idx_width(NReq)
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] grant_o,
    output logic            valid_o
);

    int unsigned cand;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = 0;
        // Walk from the farthest offset to the nearest so the nearest requester wins.
        for (int unsigned i = NReq; i >= 1; i--) begin
            cand = 32'(last_i) + i;
            if (cand >= NReq) begin
                cand = cand - NReq;
            end
            if (req_i[IdxW'(cand)]) begin
                grant_o = IdxW'(cand);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wvb_rdout_sched.sv
// Waveform-buffer readout scheduler: round-robin grant, header fetch, sample strobing.
// Defining WVB_RDOUT_TIMEOUT_EN adds a stall timeout that aborts an event and flags it.
module wvb_rdout_sched
    import wvb_rdout_pkg::*;
#(
    parameter int unsigned P_N_CHAN    = DefNChan,
    parameter int unsigned P_ADR_WIDTH = DefAdrWidth,
    parameter int unsigned P_HDR_LAT   = DefHdrLat,
    parameter int unsigned P_TIMEOUT   = DefTimeout,
    localparam int unsigned IdxW = idx_width(P_N_CHAN)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [P_N_CHAN-1:0]    chan_en_i,
    input  logic [P_N_CHAN-1:0]    hdr_empty_i,
    input  logic [P_ADR_WIDTH-1:0] sel_start_addr_i,
    input  logic [P_ADR_WIDTH-1:0] sel_stop_addr_i,
    input  logic                   dout_ready_i,
    output logic [IdxW-1:0]        sel_chan_o,
    output logic [P_N_CHAN-1:0]    hdr_rdreq_o,
    output logic [P_N_CHAN-1:0]    wvb_rdreq_o,
    output logic [P_N_CHAN-1:0]    wvb_rddone_o,
    output logic                   evt_start_o,
    output logic [P_ADR_WIDTH:0]   evt_len_o,
    output logic                   busy_o,
    output logic                   timeout_err_o
);

    localparam int unsigned LenW  = P_ADR_WIDTH + 1;
    localparam int unsigned WaitW = idx_width(P_HDR_LAT);

    logic [1:0]            rst_sync_q;
    logic                  rst_int_n;
    rdout_state_e          state_q, state_d;
    logic [IdxW-1:0]       sel_q, sel_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic [LenW-1:0]       cnt_q, cnt_d;
    logic [LenW-1:0]       len_q, len_d;
    logic [P_N_CHAN-1:0]   req;
    logic [IdxW-1:0]       grant_idx;
    logic                  grant_valid;
    logic [P_ADR_WIDTH-1:0] addr_diff;
    logic [LenW-1:0]       len_calc;
    logic [P_N_CHAN-1:0]   chan_oh;
    logic                  hdr_pulse;
    logic                  strobe;
    logic                  done_pulse;
    logic                  evt_start;

`ifdef WVB_RDOUT_TIMEOUT_EN
    localparam int unsigned ToW = idx_width(P_TIMEOUT);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           err_q, err_d;
`else
    logic           unused_timeout;
    assign unused_timeout = (P_TIMEOUT == 0);
`endif

    // Assert asynchronously, release only after two clean clock edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    assign req = chan_en_i & ~hdr_empty_i;

    wvb_rr_arb #(
        .NReq (P_N_CHAN)
    ) u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (grant_idx),
        .valid_o (grant_valid)
    );

    // Modular difference makes a wrapped buffer region come out naturally.
    assign addr_diff = sel_stop_addr_i - sel_start_addr_i;
    assign len_calc  = {1'b0, addr_diff} + LenW'(1);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        wait_d     = wait_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        hdr_pulse  = 1'b0;
        strobe     = 1'b0;
        done_pulse = 1'b0;
        evt_start  = 1'b0;
`ifdef WVB_RDOUT_TIMEOUT_EN
        to_cnt_d   = '0;
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    sel_d   = grant_idx;
                    state_d = StHdrRd;
                end
            end
            StHdrRd: begin
                hdr_pulse = 1'b1;
                wait_d    = '0;
                state_d   = StHdrWait;
            end
            StHdrWait: begin
                if (wait_q == WaitW'(P_HDR_LAT - 1)) begin
                    evt_start = 1'b1;
                    len_d     = len_calc;
                    cnt_d     = len_calc;
                    state_d   = StData;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StData: begin
                strobe = dout_ready_i;
                if (dout_ready_i) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LenW'(1)) begin
                        state_d = StDone;
                    end
                end
`ifdef WVB_RDOUT_TIMEOUT_EN
                else if (to_cnt_q == ToW'(P_TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                done_pulse = 1'b1;
                last_d     = sel_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= IdxW'(P_N_CHAN - 1);
            wait_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

`ifdef WVB_RDOUT_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign timeout_err_o = err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign chan_oh      = P_N_CHAN'(1) << sel_q;
    assign sel_chan_o   = sel_q;
    assign hdr_rdreq_o  = hdr_pulse  ? chan_oh : '0;
    assign wvb_rdreq_o  = strobe     ? chan_oh : '0;
    assign wvb_rddone_o = done_pulse ? chan_oh : '0;
    assign evt_start_o  = evt_start;
    assign evt_len_o    = evt_start ? len_calc : len_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/wvb_rdout_sched.md
WVB_RDOUT_SCHED -- requirements
Module: wvb_rdout_sched

Interface
REQ-001 SHALL have parameter P_N_CHAN, default 4, number of waveform buffer channels served.
REQ-002 SHALL have parameter P_ADR_WIDTH, default 12, waveform buffer address width.
REQ-003 SHALL have parameter P_HDR_LAT, default 2, cycles from hdr_rdreq to rd-address controller loading start_addr.
REQ-004 SHALL have parameter P_TIMEOUT, default 1023, stall cycles before abort (timeout build only).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port chan_en  in  P_N_CHAN  per-channel service enable mask.
REQ-008 SHALL have port hdr_empty  in  P_N_CHAN  per-channel header FIFO empty flag.
REQ-009 SHALL have port sel_start_addr  in  P_ADR_WIDTH  start address of selected channel's header, externally muxed by sel_chan.
REQ-010 SHALL have port sel_stop_addr  in  P_ADR_WIDTH  stop address, same mux.
REQ-011 SHALL have port dout_ready  in  1  downstream consumer accepts one sample this cycle.
REQ-012 SHALL have port sel_chan  out  clog2(P_N_CHAN)  channel currently granted.
REQ-013 SHALL have port hdr_rdreq  out  P_N_CHAN  one-hot header read pulse.
REQ-014 SHALL have port wvb_rdreq  out  P_N_CHAN  one-hot sample read strobe.
REQ-015 SHALL have port wvb_rddone  out  P_N_CHAN  one-hot end-of-event pulse.
REQ-016 SHALL have port evt_start  out  1  one-cycle pulse, event length valid.
REQ-017 SHALL have port evt_len  out  P_ADR_WIDTH+1  samples in event.
REQ-018 SHALL have port busy  out  1  high in any state but IDLE.
REQ-019 SHALL have port timeout_err  out  1  sticky abort flag (timeout build only, else tied 0).

Function
REQ-020 SHALL implement FSM states IDLE, HDR_RD, HDR_WAIT, DATA, DONE.
REQ-021 IDLE: when any bit of (chan_en & ~hdr_empty) set, SHALL grant by round-robin starting after last-served channel, latch sel_chan, go HDR_RD.
REQ-022 HDR_RD: SHALL pulse hdr_rdreq[sel_chan] exactly one cycle, go HDR_WAIT.
REQ-023 HDR_WAIT: SHALL hold P_HDR_LAT cycles; last cycle SHALL sample sel_start/stop_addr, compute evt_len, pulse evt_start, go DATA; first wvb_rdreq no earlier than hdr_rdreq cycle + P_HDR_LAT + 1.
REQ-024 evt_len SHALL be ((stop - start) mod 2^P_ADR_WIDTH) + 1, range 1..2^P_ADR_WIDTH; stop < start is buffer wrap, not error.
REQ-025 DATA: wvb_rdreq[sel_chan] SHALL equal dout_ready; remaining count decrements per strobe; after strobe taking count to 0 go DONE.
REQ-026 DONE: SHALL pulse wvb_rddone[sel_chan] one cycle, record sel_chan as last-served, return IDLE; no new grant same cycle.
REQ-027 Changes of chan_en/hdr_empty after grant SHALL NOT affect event in progress.
REQ-028 At most one bit of hdr_rdreq|wvb_rdreq|wvb_rddone SHALL be set per cycle.

Reset
REQ-029 On rst_n low, state SHALL be IDLE, all outputs 0, counters 0, last-served = P_N_CHAN-1 (channel 0 first), asynchronously.
REQ-030 Reset mid-event SHALL abandon event without wvb_rddone; deassertion synchronised inside block.

Configuration
REQ-031 With WVB_RDOUT_TIMEOUT_EN defined: in DATA, P_TIMEOUT consecutive cycles with dout_ready low SHALL force DONE (wvb_rddone pulse) and set timeout_err until reset.
REQ-032 Without WVB_RDOUT_TIMEOUT_EN: no timeout counter; DATA waits indefinitely; timeout_err constant 0.

Structure
REQ-033 Package wvb_rdout_pkg SHALL hold FSM state typedef and default parameter constants.
REQ-034 Round-robin grant SHALL be sub-module wvb_rr_arb (req, last, grant index, valid).

Verification
REQ-035 Ch2 only non-empty, start=10, stop=13 -> hdr_rdreq[2] at t, evt_len=4, wvb_rdreq[2] ×4 from t+3, wvb_rddone[2] next.
REQ-036 Wrap: start=4094, stop=1 -> evt_len=4, four strobes.
REQ-037 Channels 0,1,3 all non-empty continuously -> grant order 0,1,3,0,1,3.
REQ-038 dout_ready toggled 1/0 -> strobes only on ready cycles, total equals evt_len.
REQ-039 rst_n low during DATA -> outputs 0 immediately, next grant channel 0, no wvb_rddone.
REQ-040 Timeout build, P_TIMEOUT=8, ready held low in DATA -> wvb_rddone after 8 cycles, timeout_err=1 sticky.
